// File: rtl/lz_denormalizer.sv
// ============================================================================
// lz_denormalizer: restores an un-normalized value from a normalized mantissa
// and its leading-zero count by right-shifting one bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lz_denormalizer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_SHIFT = 2'd1;
  localparam logic [1:0]    S_DONE  = 2'd2;
  localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic             w_over;
  logic [CW-1:0]    w_cnt_clamped;
  logic             w_err_in;

  // Consistency of the incoming pair: the count must match the mantissa shape.
  assign w_over        = (in_count > C_WIDTH);
  assign w_cnt_clamped = w_over ? C_WIDTH : in_count;
  assign w_err_in      = w_over
                       || ((in_count < C_WIDTH) && !in_mant[WIDTH-1])
                       || ((in_count == C_WIDTH) && (in_mant != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = in_mant;
          cnt_d   = w_cnt_clamped;
          err_d   = w_err_in;
          state_d = (w_cnt_clamped == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - C_ONE;
        // Leave on the same edge as the final shift.
        if (cnt_q == C_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    out_data  = (state_q == S_DONE) ? shreg_q : '0;
    out_err   = (state_q == S_DONE) && err_q;
  end

endmodule

`default_nettype wire

// File: doc/lz_denormalizer.md
Name: lz_denormalizer

Overview:
- Inverse of the leading-zero counter path: takes a normalized mantissa (MSB = 1) and the leading-zero count produced for it, and restores the original un-normalized value by right-shifting one bit per clock.
- Sits after a normalize/compute stage, so that `lzc(x)` followed by `x << lzc(x)` round-trips back to `x`.
- Iterative, single-operation-in-flight engine with valid/ready on both sides.

Parameters:
- WIDTH, 8, data width of mantissa and result.
- CW, 4, count width; must equal $clog2(WIDTH+1) so the count can express 0..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers in_mant/in_count.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- in_mant  input  WIDTH  normalized mantissa.
- in_count  input  CW  leading-zero count (number of right shifts).
- out_valid  output  1  out_data/out_err valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  restored value.
- out_err  output  1  input was inconsistent (see rules below); qualified by out_valid.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_err=0, busy=0, in_ready=1 (once rst_n has deasserted).
  - Internal shift register and remaining-count register are cleared.
  - Reset mid-SHIFT or mid-DONE abandons the operation; no result is ever emitted for it.
- FSM: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready:
    - Latch in_mant into the shift register.
    - Latch the remaining count as min(in_count, WIDTH).
    - Latch err = (in_count > WIDTH) || (in_count < WIDTH && in_mant[WIDTH-1]==0) || (in_count == WIDTH && in_mant != 0).
    - If the clamped count is 0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, shift the register right by 1 with zero fill and decrement the remaining count.
  - When the count decrements to 0, go to DONE on the same edge the last shift occurs.
- DONE:
  - out_valid=1; out_data=shift register; out_err=latched err.
  - Outputs stay stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the following cycle.
- Latency:
  - out_valid rises N+1 cycles after the accepting edge, where N = clamped count.
  - N=0 → 1 cycle; N=WIDTH → WIDTH+1 cycles.
- Throughput:
  - in_ready is low in SHIFT and DONE, so there is no overlap of operations.
  - The earliest next acceptance is the cycle after the output handshake.
  - in_valid asserted while busy is ignored; upstream must hold it until in_ready.
- Arithmetic:
  - Shifts are logical with zero fill.
  - in_count==WIDTH yields out_data=0; this matches the LZC result for an all-zero input.
  - in_count > WIDTH is clamped to WIDTH: result is 0 and out_err=1.
- Error rules:
  - out_err never blocks the result; data is still produced per the shift rules.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Round trip, x=0000_0101:
  - Drive in_mant=1010_0000, in_count=5.
  - Required: out_data=0000_0101, out_err=0, out_valid 6 cycles after accept.
- Zero shift:
  - Drive in_mant=1000_0000, in_count=0.
  - Required: out_data=1000_0000 one cycle after accept; then in_mant=1111_1111, count=0 → 1111_1111.
- All-zero case:
  - Drive in_mant=0000_0000, in_count=8 → out_data=0, out_err=0, latency 9.
  - Then in_count=12 → out_data=0, out_err=1, latency 9.
- Inconsistent input and backpressure:
  - Drive in_mant=0100_0000, in_count=1 → out_data=0010_0000, out_err=1.
  - Hold out_ready=0 for 4 cycles: out_valid/out_data/out_err remain stable.
  - in_ready stays 0 and a concurrent in_valid is not accepted.
- Back-to-back operations and full LZC sweep:
  - For each k in 0..7, drive mant=1000_0000, count=k → out_data=1000_0000>>k, with out_ready tied high.
  - Next accept occurs the cycle after each output handshake.
- Reset mid-operation:
  - Accept count=7; drop rst_n after 3 SHIFT cycles.
  - Required: out_valid=0, busy=0, in_ready=1 immediately after reset.
  - No stale result appears.
  - The next operation (mant=1100_0000, count=2) returns 0011_0000.
